// File: rtl/fpu_pkg.sv
// Shared FPU package: widths, limits and the normalize/round stage state type.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned WORK_W = 27;
  localparam int unsigned LZ_W   = 5;

  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [MANT_W-1:0] HIDDEN  = 24'h800000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } fpu_nr_state_t;

endpackage

// File: rtl/fpu_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero input.
module fpu_lzc24
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] data_i,
  output logic [LZ_W-1:0]   count_o
);

  // Scan upward so the highest set bit writes the count last.
  always_comb begin
    count_o = LZ_W'(MANT_W);
    for (int i = 0; i < int'(MANT_W); i++) begin
      if (data_i[i]) count_o = LZ_W'(int'(MANT_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_norm_round.sv
// Post-add normalize-and-round stage producing a packed binary32 result and flags.
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even, else truncation.
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_carry,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_inexact
);

  fpu_nr_state_t     state_q;
  logic [WORK_W-1:0] w_q;
  logic [EXP_W:0]    e_q;
  logic              s_q;
  logic              c_q;
  logic [31:0]       result_q;
  logic              ovf_q;
  logic              unf_q;
  logic              inx_q;
  logic              out_valid_q;

  logic [LZ_W-1:0]   lz;
  logic [WORK_W-1:0] w_car_d;
  logic [WORK_W-1:0] w_shl_d;
  logic [EXP_W:0]    e_inc_d;
  logic              inc;
  logic [MANT_W-1:0] frac_sum;
  logic              mant_ovf;
  logic [EXP_W:0]    e_rnd_d;

  fpu_lzc24 u_lzc (
    .data_i  (w_q[WORK_W-1:3]),
    .count_o (lz)
  );

  // Carry renormalize: shift right one, keep the lost bit in sticky.
  assign w_car_d = (w_q >> 1) | {HIDDEN, 3'b000} | WORK_W'(w_q[0]);
  assign w_shl_d = w_q << lz;
  assign e_inc_d = e_q + (EXP_W+1)'(1);

`ifdef FPU_ROUND_NEAREST_EN
  assign inc = w_q[2] & (w_q[1] | w_q[0] | w_q[3]);
`else
  assign inc = 1'b0;
`endif

  // Hidden bit is always set in ROUND, so a carry out of the fraction is a mantissa overflow.
  assign frac_sum = {1'b0, w_q[WORK_W-2:3]} + MANT_W'(inc);
  assign mant_ovf = frac_sum[MANT_W-1] & w_q[WORK_W-1];
  assign e_rnd_d  = mant_ovf ? e_inc_d : e_q;

  assign in_ready = (state_q == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      c_q         <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            w_q     <= {in_mant, in_grs};
            e_q     <= {1'b0, in_exp};
            s_q     <= in_sign;
            c_q     <= in_carry;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (e_q[EXP_W-1:0] == EXP_MAX) begin
            result_q    <= {s_q, EXP_MAX, w_q[WORK_W-2:3]};
            {ovf_q, unf_q, inx_q} <= 3'b000;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (c_q) begin
            if (e_inc_d == (EXP_W+1)'(EXP_MAX)) begin
              result_q    <= {s_q, EXP_MAX, 23'd0};
              {ovf_q, unf_q, inx_q} <= 3'b101;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              w_q     <= w_car_d;
              e_q     <= e_inc_d;
              state_q <= ROUND;
            end
          end else if (w_q == '0) begin
            result_q    <= 32'h0000_0000;
            {ovf_q, unf_q, inx_q} <= 3'b000;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if ((EXP_W+1)'(lz) >= e_q) begin
            result_q    <= {s_q, 31'd0};
            {ovf_q, unf_q, inx_q} <= 3'b011;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            w_q     <= w_shl_d;
            e_q     <= e_q - (EXP_W+1)'(lz);
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (e_rnd_d >= (EXP_W+1)'(EXP_MAX)) begin
            result_q <= {s_q, EXP_MAX, 23'd0};
            ovf_q    <= 1'b1;
          end else begin
            result_q <= {s_q, e_rnd_d[EXP_W-1:0], frac_sum[MANT_W-2:0]};
            ovf_q    <= 1'b0;
          end
          unf_q       <= 1'b0;
          inx_q       <= |w_q[2:0];
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign flag_ovf     = ovf_q;
  assign flag_unf     = unf_q;
  assign flag_inexact = inx_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Self-checking bench for fpu_norm_round: directed corner cases plus random operands vs a value-level model.
module tb_fpu_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_carry;
  logic [23:0] in_mant;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inexact;

  int checks = 0;
  int errors = 0;

  localparam int unsigned TOP_BIT = 32'h0400_0000;

  fpu_norm_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_carry     (in_carry),
    .in_mant      (in_mant),
    .in_grs       (in_grs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inexact (flag_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Value-level reference: treat the 27-bit working value as an integer, normalize, round.
  function automatic void model(input logic s, input logic [7:0] ex, input logic c,
                                input logic [23:0] m, input logic [2:0] g,
                                output logic [31:0] res, output logic [2:0] flg,
                                output int lat);
    int unsigned v, keep, rem;
    int e, lz;
    bit rnd_up;
    lat = 2;
    flg = 3'b000;
    res = 32'h0;
    if (ex == 8'hFF) begin
      res = {s, 8'hFF, m[22:0]};
      return;
    end
    v = 32'({m, g});
    e = int'(ex);
    if (c) begin
      v = (v >> 1) | (v & 32'd1) | TOP_BIT;
      e = e + 1;
      if (e == 255) begin
        res = {s, 8'hFF, 23'd0};
        flg = 3'b101;
        return;
      end
    end else begin
      if (v == 0) return;
      lz = 0;
      while (v < TOP_BIT) begin
        v = v << 1;
        lz++;
      end
      if (lz >= e) begin
        res = {s, 31'd0};
        flg = 3'b011;
        return;
      end
      e = e - lz;
    end
    lat  = 3;
    keep = v >> 3;
    rem  = v & 32'd7;
`ifdef FPU_ROUND_NEAREST_EN
    rnd_up = (rem > 4) || (rem == 4 && keep[0]);
`else
    rnd_up = 1'b0;
`endif
    if (rnd_up) keep = keep + 1;
    if (keep == 32'h0100_0000) begin
      keep = 32'h0080_0000;
      e = e + 1;
    end
    flg[0] = (rem != 0);
    if (e >= 255) begin
      res    = {s, 8'hFF, 23'd0};
      flg[2] = 1'b1;
    end else begin
      res = {s, 8'(e), keep[22:0]};
    end
  endfunction

  // Present one operand, wait (bounded) for out_valid; lat counts cycles until it is seen.
  task automatic run_op(input logic s, input logic [7:0] e, input logic c,
                        input logic [23:0] m, input logic [2:0] g, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_carry = c;
    in_mant  = m;
    in_grs   = g;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic c,
                          input logic [23:0] m, input logic [2:0] g,
                          input logic [31:0] want, input logic [2:0] want_flg, input int want_lat);
    int lat;
    run_op(s, e, c, m, g, lat);
    check({tag, "_res"}, result, want);
    check({tag, "_flg"}, 32'({flag_ovf, flag_unf, flag_inexact}), 32'(want_flg));
    check({tag, "_lat"}, 32'(lat), 32'(want_lat));
    finish_op();
  endtask

  initial begin
    int lat, mlat;
    logic [31:0] mres;
    logic [2:0]  mflg;
    logic        s, c;
    logic [7:0]  e;
    logic [23:0] m;
    logic [2:0]  g;
    int          sel;

    rst = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h0; in_carry = 1'b0;
    in_mant = 24'h0; in_grs = 3'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", 32'({flag_ovf, flag_unf, flag_inexact}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    directed("one_plus_one", 1'b0, 8'h7F, 1'b1, 24'h000000, 3'b000, 32'h4000_0000, 3'b000, 3);
    directed("cancel", 1'b0, 8'h80, 1'b0, 24'h000001, 3'b000, 32'h3480_0000, 3'b000, 3);
`ifdef FPU_ROUND_NEAREST_EN
    directed("tie", 1'b0, 8'h7F, 1'b0, 24'hFFFFFF, 3'b100, 32'h4000_0000, 3'b001, 3);
    directed("round_to_inf", 1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b111, 32'h7F80_0000, 3'b101, 3);
    directed("carry_sticky", 1'b0, 8'h7F, 1'b1, 24'h000001, 3'b001, 32'h4000_0001, 3'b001, 3);
`else
    directed("tie", 1'b0, 8'h7F, 1'b0, 24'hFFFFFF, 3'b100, 32'h3FFF_FFFF, 3'b001, 3);
    directed("round_to_inf", 1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b111, 32'h7F7F_FFFF, 3'b001, 3);
    directed("carry_sticky", 1'b0, 8'h7F, 1'b1, 24'h000001, 3'b001, 32'h4000_0000, 3'b001, 3);
`endif
    directed("carry_ovf", 1'b0, 8'hFE, 1'b1, 24'h000000, 3'b000, 32'h7F80_0000, 3'b101, 2);
    directed("flush", 1'b1, 8'h03, 1'b0, 24'h000010, 3'b000, 32'h8000_0000, 3'b011, 2);
    directed("zero", 1'b1, 8'h40, 1'b0, 24'h000000, 3'b000, 32'h0000_0000, 3'b000, 2);
    directed("nan_pass", 1'b1, 8'hFF, 1'b0, 24'h400001, 3'b000, 32'hFFC0_0001, 3'b000, 2);

    // Back-pressure: result held, no new acceptance while the consumer stalls.
    run_op(1'b0, 8'h7F, 1'b1, 24'h000000, 3'b000, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'h4000_0000);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_valid_drop", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);

    // Reset while the operand sits in NORM.
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'h80; in_carry = 1'b0; in_mant = 24'h000001; in_grs = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_valid", 32'(out_valid), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_result", result, 32'h0);

    for (int t = 0; t < 300; t++) begin
      s = 1'($urandom);
      c = 1'($urandom);
      g = 3'($urandom);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: e = 8'hFF;
        1: e = 8'($urandom_range(0, 30));
        2: e = 8'($urandom_range(253, 254));
        default: e = 8'($urandom_range(1, 254));
      endcase
      m = 24'($urandom) >> $urandom_range(0, 23);
      if (m == 24'h0) m = 24'h1;
      if ($urandom_range(0, 15) == 0) begin
        c = 1'b0; m = 24'h0; g = 3'b000;
      end
      model(s, e, c, m, g, mres, mflg, mlat);
      run_op(s, e, c, m, g, lat);
      check("rand_res", result, mres);
      check("rand_flg", 32'({flag_ovf, flag_unf, flag_inexact}), 32'(mflg));
      check("rand_lat", 32'(lat), 32'(mlat));
      finish_op();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
